// File: rtl/alarm_clock_core_if.sv
// Control/status bundle between the front end, the alarm clock core and the display driver.
// The core takes the slave modport; the board top or bench drives the master side.
interface alarm_clock_core_if #(
  parameter int unsigned N_ALARMS = 2
);
  localparam int unsigned IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

  logic          load;
  logic [3:0]    hourdec_init;
  logic [3:0]    hourone_init;
  logic [3:0]    mindec_init;
  logic [3:0]    minone_init;
  logic          alm_wr;
  logic [IW-1:0] alm_idx;
  logic [7:0]    alm_hour;
  logic [7:0]    alm_min;
  logic          alm_en;
  logic          stop;
  logic          snooze;

  logic [3:0]    hourdec_now;
  logic [3:0]    hourone_now;
  logic [3:0]    mindec_now;
  logic [3:0]    minone_now;
  logic [3:0]    secdec_now;
  logic [3:0]    secone_now;
  logic          sec_tick;
  logic          ring;
  logic [IW-1:0] ring_idx;

  modport master (
    output load, hourdec_init, hourone_init, mindec_init, minone_init,
    output alm_wr, alm_idx, alm_hour, alm_min, alm_en, stop, snooze,
    input  hourdec_now, hourone_now, mindec_now, minone_now, secdec_now, secone_now,
    input  sec_tick, ring, ring_idx
  );

  modport slave (
    input  load, hourdec_init, hourone_init, mindec_init, minone_init,
    input  alm_wr, alm_idx, alm_hour, alm_min, alm_en, stop, snooze,
    output hourdec_now, hourone_now, mindec_now, minone_now, secdec_now, secone_now,
    output sec_tick, ring, ring_idx
  );
endinterface

// File: rtl/alarm_clock_core.sv
// BCD HH:MM:SS alarm clock with N alarm channels, ring/stop/auto-stop.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and snooze counter.
module alarm_clock_core #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned N_ALARMS   = 2,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic              clk,
  input  logic              rstn,
  alarm_clock_core_if.slave io
);
  localparam int unsigned IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned RW = 8;
  localparam int unsigned SW = 12;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING} state_t;
`endif

  // HH:MM legality shared by time load and alarm write
  function automatic logic hhmm_ok(input logic [3:0] hd, input logic [3:0] ho,
                                   input logic [3:0] md, input logic [3:0] mo);
    return ((hd < 4'd2 && ho <= 4'd9) || (hd == 4'd2 && ho <= 4'd3)) &&
           (md <= 4'd5) && (mo <= 4'd9);
  endfunction

  logic [3:0]    hd_q, ho_q, md_q, mo_q, sd_q, so_q;
  logic [3:0]    hd_d, ho_d, md_d, mo_d, sd_d, so_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  logic [7:0]    alm_h_q [N_ALARMS];
  logic [7:0]    alm_m_q [N_ALARMS];
  logic [N_ALARMS-1:0] alm_en_q;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [IW-1:0] ring_idx_q, ring_idx_d;
  logic          ring_q, ring_d;
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`else
  logic          unused_snz_c;
  assign unused_snz_c = io.snooze ^ (SNOOZE_MIN == 0) ^ (SW == 0);
`endif

  logic          load_ok_c, alm_ok_c, match_c;
  logic [IW-1:0] match_idx_c;

  assign load_ok_c = hhmm_ok(io.hourdec_init, io.hourone_init, io.mindec_init, io.minone_init);
  assign alm_ok_c  = hhmm_ok(io.alm_hour[7:4], io.alm_hour[3:0], io.alm_min[7:4], io.alm_min[3:0]);

  // Prescaler and time of day; a legal load overrides the terminal count
  always_comb begin : time_next
    hd_d    = hd_q;
    ho_d    = ho_q;
    md_d    = md_q;
    mo_d    = mo_q;
    sd_d    = sd_q;
    so_d    = so_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (io.load && load_ok_c) begin
      hd_d    = io.hourdec_init;
      ho_d    = io.hourone_init;
      md_d    = io.mindec_init;
      mo_d    = io.minone_init;
      sd_d    = 4'd0;
      so_d    = 4'd0;
      presc_d = '0;
    end else if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = 4'd0;
        if (sd_q != 4'd5) begin
          sd_d = sd_q + 4'd1;
        end else begin
          sd_d = 4'd0;
          if (mo_q != 4'd9) begin
            mo_d = mo_q + 4'd1;
          end else begin
            mo_d = 4'd0;
            if (md_q != 4'd5) begin
              md_d = md_q + 4'd1;
            end else begin
              md_d = 4'd0;
              if (hd_q == 4'd2 && ho_q == 4'd3) begin
                hd_d = 4'd0;
                ho_d = 4'd0;
              end else if (ho_q == 4'd9) begin
                ho_d = 4'd0;
                hd_d = hd_q + 4'd1;
              end else begin
                ho_d = ho_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : time_reg
    if (!rstn) begin
      hd_q    <= 4'd0;
      ho_q    <= 4'd0;
      md_q    <= 4'd0;
      mo_q    <= 4'd0;
      sd_q    <= 4'd0;
      so_q    <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      hd_q    <= hd_d;
      ho_q    <= ho_d;
      md_q    <= md_d;
      mo_q    <= mo_d;
      sd_q    <= sd_d;
      so_q    <= so_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Alarm register file; out-of-range indices and illegal times are dropped
  always_ff @(posedge clk or negedge rstn) begin : alarm_reg
    if (!rstn) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_h_q[i]  <= 8'd0;
        alm_m_q[i]  <= 8'd0;
        alm_en_q[i] <= 1'b0;
      end
    end else if (io.alm_wr && alm_ok_c) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (io.alm_idx == IW'(i)) begin
          alm_h_q[i]  <= io.alm_hour;
          alm_m_q[i]  <= io.alm_min;
          alm_en_q[i] <= io.alm_en;
        end
      end
    end
  end

  // Descending scan so the lowest matching channel ends up selected
  always_comb begin : match_scan
    match_c     = 1'b0;
    match_idx_c = '0;
    if (tick_q && sd_q == 4'd0 && so_q == 4'd0) begin
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
        if (alm_en_q[i] && alm_h_q[i] == {hd_q, ho_q} && alm_m_q[i] == {md_q, mo_q}) begin
          match_c     = 1'b1;
          match_idx_c = IW'(i);
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    ring_idx_d = ring_idx_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (match_c) begin
          state_d    = ST_RINGING;
          ring_idx_d = match_idx_c;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (io.stop) begin
          state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (io.snooze) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = SW'(SNOOZE_MIN * 60);
`endif
        end else if (tick_q) begin
          if (ring_cnt_q == RW'(RING_SEC - 1)) state_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (io.stop) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          snz_cnt_d = snz_cnt_q - SW'(1);
          if (snz_cnt_q == SW'(1)) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    ring_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk or negedge rstn) begin : fsm_reg
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      ring_idx_q <= '0;
      ring_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      ring_idx_q <= ring_idx_d;
      ring_q     <= ring_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  assign io.hourdec_now = hd_q;
  assign io.hourone_now = ho_q;
  assign io.mindec_now  = md_q;
  assign io.minone_now  = mo_q;
  assign io.secdec_now  = sd_q;
  assign io.secone_now  = so_q;
  assign io.sec_tick    = tick_q;
  assign io.ring        = ring_q;
  assign io.ring_idx    = ring_idx_q;
endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Parametrised single-clock alarm clock core: BCD HH:MM:SS timekeeping plus N programmable alarm channels with ring, stop, auto-stop and snooze.

- The seconds tick comes from an internal clock-enable prescaler, not a derived clock, so all logic runs on `clk`.
- It sits under the board top, between the button/switch front end and the 7-segment display driver.

## Interface
Parameters:
- `TICK_DIV`, 100000000: `clk` cycles per second. Legal range ≥ 2.
- `N_ALARMS`, 2: number of alarm channels. Legal range 1–8.
- `RING_SEC`, 60: seconds an alarm rings before auto-stop. Legal range 1–255.
- `SNOOZE_MIN`, 5: snooze interval in minutes. Legal range 1–59.

Ports (`IW` = max(1, $clog2(N_ALARMS))):
- `clk`  in  1  system clock; the single clock of the block.
- `rstn`  in  1  reset, asynchronous, active-low.
- `load`  in  1  one-cycle strobe: load the time from the `*_init` inputs.
- `hourdec_init`, `hourone_init`, `mindec_init`, `minone_init`  in  4 each  BCD time to load.
- `alm_wr`  in  1  one-cycle strobe: write alarm channel `alm_idx`.
- `alm_idx`  in  IW  alarm channel index.
- `alm_hour`  in  8  BCD hour, {dec, one}.
- `alm_min`  in  8  BCD minute, {dec, one}.
- `alm_en`  in  1  channel enable.
- `stop`  in  1  level input: stop ringing or cancel snooze.
- `snooze`  in  1  level input: snooze the ringing alarm.
- `hourdec_now`, `hourone_now`, `mindec_now`, `minone_now`, `secdec_now`, `secone_now`  out  4 each  current time, BCD.
- `sec_tick`  out  1  one-cycle pulse in the first cycle a new second is shown.
- `ring`  out  1  alarm sounding.
- `ring_idx`  out  IW  channel that caused the current ring or snooze.

## Operation
Reset values (`rstn`=0):
- Time 00:00:00; prescaler 0.
- All alarms 00:00, disabled.
- FSM IDLE; `ring`=0, `ring_idx`=0, `sec_tick`=0.

Prescaler:
- Counts 0..`TICK_DIV`-1. The terminal count advances the time one second.

Time counting:
- Seconds ones 9→0 carries to seconds tens. Seconds tens 5→0 carries to minutes.
- Minutes count the same way as seconds and carry to hours.
- Hours count 23→00, so 23:59:59 wraps to 00:00:00.

Load:
- Synchronous. Sets HH:MM, clears seconds and the prescaler.
- Load beats a same-cycle prescaler terminal count; no `sec_tick` is produced for that cycle.
- An invalid value (hour > 23, minute tens > 5, any digit > 9) is ignored and the time is unchanged.

Alarm write:
- Synchronous. An invalid BCD value is ignored, as for load.
- A write to the channel currently ringing does not affect the current ring.

Match:
- Evaluated only in cycles with `sec_tick`=1.
- Condition: seconds == 00, and the channel's HH:MM equals the current time, and the channel is enabled.
- If several channels match, the lowest index wins; the others are dropped.
- A time loaded to exactly an alarm time never fires; alarms fire only on tick-driven transitions.

FSM:
- IDLE → RINGING on a match. Latches `ring_idx` and clears the second counter.
- RINGING → IDLE on `stop`=1, or when the second counter reaches `RING_SEC`.
- RINGING → SNOOZE on `snooze`=1 with `stop`=0. Loads the snooze counter with `SNOOZE_MIN`*60.
- SNOOZE: decrements the snooze counter on each `sec_tick`. At 0 → RINGING, with the second counter cleared and `ring_idx` kept.
- SNOOZE → IDLE on `stop`=1.
- `stop` and `snooze` in the same cycle: `stop` wins.
- Matches that occur in RINGING or SNOOZE are ignored.
- `load` does not change the FSM state; the ring and snooze counters count ticks, not wall-clock time.
- `ring` = (state == RINGING), registered.

## Timing
- `sec_tick` pulses every `TICK_DIV` cycles. It is high in the same cycle the `*_now` outputs first show the new value.
- Load: `*_now` shows the loaded value the cycle after the `load` strobe. The next `sec_tick` comes `TICK_DIV` cycles after that.
- Ring start: `ring` rises on the edge after the matching `sec_tick` cycle, i.e. 1 cycle of latency.
- `stop`/`snooze`: sampled each cycle. `ring` falls on the next edge.
- Auto-stop: `ring` falls one cycle after the `RING_SEC`-th `sec_tick` counted in RINGING.
- Snooze re-ring: `ring` rises one cycle after the `SNOOZE_MIN`*60-th `sec_tick` after entry to SNOOZE.
- `rstn` falling mid-operation: every output goes to its reset value immediately, without waiting for a clock edge.

## Configuration
`ALARM_SNOOZE_EN`:
- Defined: the SNOOZE state and snooze counter are built, and `snooze` behaves as specified above.
- Undefined: `snooze` is ignored, the SNOOZE state and counter are not built, and `SNOOZE_MIN` is unused. RINGING leaves only on `stop` or auto-stop.

## Test plan
All scenarios use `TICK_DIV`=4.
1. Load 23:59, run 60 ticks → `sec_tick` every 4 cycles; time reaches 00:00:00 with hour wrap.
2. Alarm 0 set to 07:30 and enabled, load 07:29, run 60 ticks → at `sec_tick` showing 07:30:00, `ring`=1 next cycle and `ring_idx`=0.
3. Alarms 1 and 2 both set to 12:00, `N_ALARMS`=4 → `ring_idx`=1. Load 12:00 directly → no ring.
4. `ALARM_SNOOZE_EN`, `SNOOZE_MIN`=1:
   - Pulse `snooze` while ringing → `ring`=0, then rises one cycle after the 60th following tick.
   - `stop` and `snooze` together → IDLE, no re-ring.
5. `RING_SEC`=3, no `stop` → `ring` falls one cycle after the 3rd tick in RINGING.
6. Load 24:00 → time unchanged. Assert `rstn`=0 while RINGING → `ring`=0 and time 00:00:00 without a clock edge.
